// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the rv32i load/store unit: funct3 codes, FSM states and
// the alignment rule used by both the aligner and the control FSM.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // funct3[1:0] encodes access size for both loads and stores (0=byte, 1=half, 2=word).
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == 2'd1) bad = offset[0];
        if (funct3[1:0] == 2'd2) bad = (offset != 2'd0);
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store strobes and replicated data, load extraction and
// sign/zero extension, and the illegal-access flag.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        illegal
);

    logic [31:0] shifted;
    logic        bad_f3;

    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = shifted;
        bad_f3    = 1'b0;
        if (we) begin
            case (funct3)
                F3_SB: begin
                    wstrb     = 4'b0001 << offset;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    wstrb     = 4'b0011 << offset;
                    wdata_rep = {2{wdata[15:0]}};
                end
                F3_SW:   wstrb = 4'b1111;
                default: bad_f3 = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
                F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
                F3_LW:   rdata_ext = shifted;
                F3_LBU:  rdata_ext = {24'd0, shifted[7:0]};
                F3_LHU:  rdata_ext = {16'd0, shifted[15:0]};
                default: bad_f3 = 1'b1;
            endcase
        end
        illegal = bad_f3 | misaligned(funct3, offset);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues one req/ack data-memory transaction per load/store, stalls the
// core while it is outstanding and returns the extended load value for writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_en,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        ls_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state_q, state_d;
    logic        we_q, fault_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] addr_q, wdata_q, ld_data_q, cnt_q;
    logic [3:0]  strb_q;

    logic        in_idle, in_req, issue, accept, timeout_hit;
    logic [2:0]  al_funct3;
    logic        al_we;
    logic [1:0]  al_offset;
    logic [3:0]  al_strb;
    logic [31:0] al_wdata, al_rdata;
    logic        al_illegal;

    assign in_idle = (state_q == StIdle);
    assign in_req  = (state_q == StReq);

    // The aligner sees the live instruction in IDLE and the latched one while in REQ.
    assign al_funct3 = in_idle ? ls_funct3 : funct3_q;
    assign al_we     = in_idle ? ls_we     : we_q;
    assign al_offset = in_idle ? addr[1:0] : offset_q;

    load_store_unit_align u_align (
        .funct3    (al_funct3),
        .we        (al_we),
        .offset    (al_offset),
        .wdata     (wdata),
        .rdata     (mem_rdata),
        .wstrb     (al_strb),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .illegal   (al_illegal)
    );

    assign issue       = in_idle && ls_en;
    assign accept      = issue && !al_illegal;
    assign timeout_hit = in_req && !mem_ack && (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StReq;
            StReq:   if (mem_ack || timeout_hit) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    assign stall     = accept || in_req;
    assign ls_fault  = (issue && al_illegal) || fault_q;
    assign ld_valid  = (state_q == StDone) && !we_q && !fault_q;
    assign ld_data   = ld_data_q;
    assign mem_req   = in_req;
    assign mem_we    = in_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = in_req ? strb_q : 4'b0000;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            funct3_q  <= 3'd0;
            offset_q  <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            strb_q    <= 4'd0;
            ld_data_q <= 32'd0;
            cnt_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            fault_q <= timeout_hit;
            if (accept) begin
                we_q     <= ls_we;
                funct3_q <= ls_funct3;
                offset_q <= addr[1:0];
                addr_q   <= {addr[31:2], 2'b00};
                strb_q   <= al_strb;
                wdata_q  <= al_wdata;
                cnt_q    <= 32'd0;
            end
            if (in_req) begin
                if (mem_ack) begin
                    if (!we_q) ld_data_q <= al_rdata;
                end else if (timeout_hit) begin
                    ld_data_q <= 32'd0;
                end else if (TIMEOUT != 0) begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; dut_a waits forever, dut_b has TIMEOUT=3.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, ls_en, ls_we, mem_ack;
    logic [2:0]  ls_funct3;
    logic [31:0] addr, wdata, mem_rdata;

    logic        a_stall, a_ld_valid, a_ls_fault, a_mem_req, a_mem_we;
    logic [31:0] a_ld_data, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic        b_stall, b_ld_valid, b_ls_fault, b_mem_req, b_mem_we;
    logic [31:0] b_ld_data, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;

    int checks = 0;
    int errors = 0;

    // Values sampled by txn for each phase of a transaction on dut_a.
    logic        iss_stall, iss_req, r_req, r_we, r_stall, d_valid, d_stall, d_fault;
    logic [31:0] r_addr, r_wdata, d_data;
    logic [3:0]  r_strb;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(0)) dut_a (
        .clk(clk), .reset(reset), .ls_en(ls_en), .ls_we(ls_we), .ls_funct3(ls_funct3),
        .addr(addr), .wdata(wdata), .stall(a_stall), .ld_data(a_ld_data),
        .ld_valid(a_ld_valid), .ls_fault(a_ls_fault), .mem_req(a_mem_req), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT(3)) dut_b (
        .clk(clk), .reset(reset), .ls_en(ls_en), .ls_we(ls_we), .ls_funct3(ls_funct3),
        .addr(addr), .wdata(wdata), .stall(b_stall), .ld_data(b_ld_data),
        .ld_valid(b_ld_valid), .ls_fault(b_ls_fault), .mem_req(b_mem_req), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue cycle, one REQ cycle acked immediately, DONE cycle; returns back in IDLE.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd);
        ls_en = 1'b1; ls_we = we; ls_funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
        @(negedge clk);
        iss_stall = a_stall; iss_req = a_mem_req;
        step();
        ls_en = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        r_req = a_mem_req; r_we = a_mem_we; r_addr = a_mem_addr;
        r_strb = a_mem_wstrb; r_wdata = a_mem_wdata; r_stall = a_stall;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        d_valid = a_ld_valid; d_data = a_ld_data; d_stall = a_stall; d_fault = a_ls_fault;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ls_en = 1'b0; ls_we = 1'b0; ls_funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        step(); step();
        @(negedge clk);
        chk("rst_stall", {31'd0, a_stall}, 32'd0);
        chk("rst_req", {31'd0, a_mem_req}, 32'd0);
        chk("rst_valid", {31'd0, a_ld_valid}, 32'd0);
        chk("rst_fault", {31'd0, a_ls_fault}, 32'd0);
        chk("rst_wstrb", {28'd0, a_mem_wstrb}, 32'd0);
        chk("rst_ld_data", a_ld_data, 32'd0);
        step();
        reset = 1'b0;
        step();

        // 1: LW
        txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF);
        chk("lw_iss_stall", {31'd0, iss_stall}, 32'd1);
        chk("lw_iss_req", {31'd0, iss_req}, 32'd0);
        chk("lw_req", {31'd0, r_req}, 32'd1);
        chk("lw_we", {31'd0, r_we}, 32'd0);
        chk("lw_addr", r_addr, 32'h100);
        chk("lw_wstrb", {28'd0, r_strb}, 32'd0);
        chk("lw_req_stall", {31'd0, r_stall}, 32'd1);
        chk("lw_done_stall", {31'd0, d_stall}, 32'd0);
        chk("lw_valid", {31'd0, d_valid}, 32'd1);
        chk("lw_data", d_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lw_valid_pulse", {31'd0, a_ld_valid}, 32'd0);
        step();

        // 2: sub-word loads
        txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h8011_2233);
        chk("lb_data", d_data, 32'hFFFF_FF80);
        chk("lb_addr", r_addr, 32'h100);
        txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h8011_2233);
        chk("lbu_data", d_data, 32'h0000_0080);
        txn(1'b0, 3'd5, 32'h102, 32'h0, 32'h8011_2233);
        chk("lhu_data", d_data, 32'h0000_8011);
        txn(1'b0, 3'd1, 32'h102, 32'h0, 32'h8011_2233);
        chk("lh_data", d_data, 32'hFFFF_8011);
        txn(1'b0, 3'd0, 32'h101, 32'h0, 32'h8011_2233);
        chk("lb1_data", d_data, 32'h0000_0022);

        // 3: stores
        txn(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 32'h1234_5678);
        chk("sb_we", {31'd0, r_we}, 32'd1);
        chk("sb_addr", r_addr, 32'h200);
        chk("sb_wstrb", {28'd0, r_strb}, 32'b0010);
        chk("sb_wdata", r_wdata, 32'hABAB_ABAB);
        chk("sb_valid", {31'd0, d_valid}, 32'd0);
        chk("sb_ld_data_kept", d_data, 32'h0000_0022);
        txn(1'b1, 3'd1, 32'h202, 32'h0000_1234, 32'h0);
        chk("sh_wstrb", {28'd0, r_strb}, 32'b1100);
        chk("sh_wdata", r_wdata, 32'h1234_1234);
        txn(1'b1, 3'd2, 32'h204, 32'hCAFE_F00D, 32'h0);
        chk("sw_wstrb", {28'd0, r_strb}, 32'b1111);
        chk("sw_wdata", r_wdata, 32'hCAFE_F00D);

        // 4: illegal accesses
        ls_en = 1'b1; ls_we = 1'b0; ls_funct3 = 3'd2; addr = 32'h102;
        @(negedge clk);
        chk("lw_mis_fault", {31'd0, a_ls_fault}, 32'd1);
        chk("lw_mis_stall", {31'd0, a_stall}, 32'd0);
        step();
        ls_we = 1'b1; ls_funct3 = 3'd1; addr = 32'h1;
        @(negedge clk);
        chk("sh_mis_fault", {31'd0, a_ls_fault}, 32'd1);
        chk("sh_mis_req", {31'd0, a_mem_req}, 32'd0);
        step();
        ls_we = 1'b0; ls_funct3 = 3'd3; addr = 32'h100;
        @(negedge clk);
        chk("ld_f3_fault", {31'd0, a_ls_fault}, 32'd1);
        step();
        ls_we = 1'b1; ls_funct3 = 3'd4; addr = 32'h100;
        @(negedge clk);
        chk("st_f3_fault", {31'd0, a_ls_fault}, 32'd1);
        step();
        ls_en = 1'b0;
        @(negedge clk);
        chk("fault_pulse", {31'd0, a_ls_fault}, 32'd0);
        chk("ill_no_req", {31'd0, a_mem_req}, 32'd0);
        step();

        // 5: ack withheld; dut_b times out after three REQ cycles
        ls_en = 1'b1; ls_we = 1'b0; ls_funct3 = 3'd2; addr = 32'h300;
        step();
        ls_en = 1'b0; addr = 32'h444;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("wait_req_%0d", i), {31'd0, a_mem_req}, 32'd1);
            chk($sformatf("wait_addr_%0d", i), a_mem_addr, 32'h300);
            chk($sformatf("wait_stall_%0d", i), {31'd0, a_stall}, 32'd1);
            if (i < 3) begin
                chk($sformatf("to_req_%0d", i), {31'd0, b_mem_req}, 32'd1);
                chk($sformatf("to_nofault_%0d", i), {31'd0, b_ls_fault}, 32'd0);
            end
            if (i == 3) begin
                chk("to_fault", {31'd0, b_ls_fault}, 32'd1);
                chk("to_req_drop", {31'd0, b_mem_req}, 32'd0);
                chk("to_valid", {31'd0, b_ld_valid}, 32'd0);
                chk("to_ld_data", b_ld_data, 32'd0);
                chk("to_stall", {31'd0, b_stall}, 32'd0);
            end
            if (i == 4) chk("to_fault_pulse", {31'd0, b_ls_fault}, 32'd0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_valid", {31'd0, a_ld_valid}, 32'd1);
        chk("late_data", a_ld_data, 32'h0BAD_F00D);
        chk("to_stray_ack", {31'd0, b_ld_valid}, 32'd0);
        step(); step();

        // 6: reset during REQ, then a stray ack in IDLE
        ls_en = 1'b1; ls_we = 1'b1; ls_funct3 = 3'd2; addr = 32'h400; wdata = 32'h1;
        step();
        ls_en = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", {31'd0, a_mem_req}, 32'd1);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("mid_rst_req", {31'd0, a_mem_req}, 32'd0);
        chk("mid_rst_we", {31'd0, a_mem_we}, 32'd0);
        chk("mid_rst_stall", {31'd0, a_stall}, 32'd0);
        chk("mid_rst_wstrb", {28'd0, a_mem_wstrb}, 32'd0);
        chk("mid_rst_ld_data", a_ld_data, 32'd0);
        reset = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_valid", {31'd0, a_ld_valid}, 32'd0);
        chk("stray_req", {31'd0, a_mem_req}, 32'd0);
        chk("stray_ld_data", a_ld_data, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
